// File: rtl/branch_pkg.sv
// Shared branch definitions: branch-type codes, controller FSM states and
// the conditional-branch classifier used by the predictor update path.
package branch_pkg;

    localparam logic [2:0] BR_EQ    = 3'd0;
    localparam logic [2:0] BR_NE    = 3'd1;
    localparam logic [2:0] BR_NEVER = 3'd2;
    localparam logic [2:0] BR_JUMP  = 3'd3;
    localparam logic [2:0] BR_LT    = 3'd4;
    localparam logic [2:0] BR_GE    = 3'd5;
    localparam logic [2:0] BR_LTU   = 3'd6;
    localparam logic [2:0] BR_GEU   = 3'd7;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } branch_state_t;

    // Only conditional branches train the history table; "never" and
    // unconditional jumps carry no useful direction information.
    function automatic logic is_conditional(input logic [2:0] br_type);
        return (br_type != BR_NEVER) && (br_type != BR_JUMP);
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: an array of 2-bit saturating counters with one
// combinational read port and one clocked update port.
module branch_bht
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr [BHT_ENTRIES];

    // Read straight from the registers, so a same-cycle update is not visible
    // until the following cycle.
    always_comb begin
        rd_taken = ctr[rd_idx][1];
    end

    // Reset every counter to weakly not-taken; otherwise saturating update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (ctr[upd_idx] != 2'b11) begin
                    ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
                end
            end else begin
                if (ctr[upd_idx] != 2'b00) begin
                    ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
                end
            end
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution and redirect controller: fetch-time prediction, outcome
// check in execute, predictor training, redirect/flush handshake with fetch
// and a saturating mispredict counter.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic [2:0]       ex_br_type,
    input  logic             ex_pred_taken,
    input  logic             br_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic             flush,
    output logic             ex_stall,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    branch_state_t    state;
    branch_state_t    state_nxt;
    logic             resolve;
    logic             actual;
    logic             mispredict;
    logic [31:0]      corr_pc;
    logic             upd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             unused_pc_bits;

    // Only the word-aligned index bits of the PCs select a table entry.
    assign rd_idx  = if_pc[IDX_W+1:2];
    assign upd_idx = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    branch_bht #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (rd_idx),
        .rd_taken  (if_pred_taken),
        .upd_en    (upd_en),
        .upd_idx   (upd_idx),
        .upd_taken (actual)
    );

    // Resolve decision: compare comparator outcome with carried prediction.
    always_comb begin
        resolve    = ex_valid && (state == IDLE);
        actual     = br_taken;
        mispredict = resolve && (actual != ex_pred_taken);
        corr_pc    = actual ? ex_target : (ex_pc + 32'd4);
        upd_en     = resolve && is_conditional(ex_br_type);
    end

    // Next-state logic: enter REDIRECT on mispredict, leave on handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (mispredict) state_nxt = REDIRECT;
            REDIRECT: if (redirect_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State, latched redirect target and saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (mispredict) begin
                redirect_pc <= corr_pc;
                if (mispredict_cnt != '1) begin
                    mispredict_cnt <= mispredict_cnt + 1'b1;
                end
            end
        end
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        redirect_valid = (state == REDIRECT);
        flush          = (state == REDIRECT);
        ex_stall       = (state == REDIRECT);
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl with a scoreboard of expected
// redirect targets and a reference model of the counter table.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic [2:0]  ex_br_type;
    logic        ex_pred_taken;
    logic        br_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
    logic        ex_stall;
    logic [1:0]  mispredict_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [1:0]  bht_m [16];
    logic [1:0]  cnt_m;

    branch_ctrl #(
        .BHT_ENTRIES (16),
        .CNT_W       (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_br_type     (ex_br_type),
        .ex_pred_taken  (ex_pred_taken),
        .br_taken       (br_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush          (flush),
        .ex_stall       (ex_stall),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
        cnt_m = 2'b00;
        exp_q.delete();
    endtask

    task automatic chk_pred(input string tag, input logic [31:0] pc);
        if_pc = pc;
        #1;
        chk(tag, {31'd0, if_pred_taken}, {31'd0, bht_m[idx_of(pc)][1]});
    endtask

    task automatic chk_redirect(input string tag, input logic exp_on);
        chk({tag, "_rv"}, {31'd0, redirect_valid}, {31'd0, exp_on});
        chk({tag, "_flush"}, {31'd0, flush}, {31'd0, exp_on});
        chk({tag, "_stall"}, {31'd0, ex_stall}, {31'd0, exp_on});
    endtask

    // Resolve one instruction while the controller is idle; the model is
    // updated and any expected redirect target is pushed to the scoreboard.
    task automatic resolve(input string tag, input logic [2:0] t, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic pred, input logic tk);
        logic mis;
        logic [31:0] exp_pc;
        int k;
        ex_valid = 1'b1; ex_br_type = t; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pred; br_taken = tk;
        #1;
        // lookup in the update cycle must still see the old counter value
        chk({tag, "_rbw"}, {31'd0, if_pred_taken}, {31'd0, bht_m[idx_of(if_pc)][1]});
        mis = (tk != pred);
        if (mis) begin
            exp_q.push_back(tk ? tgt : pc + 32'd4);
            if (cnt_m != 2'b11) cnt_m = cnt_m + 2'b01;
        end
        if (t != 3'd2 && t != 3'd3) begin
            k = idx_of(pc);
            if (tk && bht_m[k] != 2'b11) bht_m[k] = bht_m[k] + 2'b01;
            else if (!tk && bht_m[k] != 2'b00) bht_m[k] = bht_m[k] - 2'b01;
        end
        tick();
        ex_valid = 1'b0;
        chk_redirect(tag, mis);
        if (mis) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                exp_pc = exp_q.pop_front();
                chk({tag, "_rpc"}, redirect_pc, exp_pc);
            end
        end
        chk({tag, "_cnt"}, {30'd0, mispredict_cnt}, {30'd0, cnt_m});
    endtask

    initial begin
        rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_target = '0;
        ex_br_type = 3'd0; ex_pred_taken = 1'b0; br_taken = 1'b0; redirect_ready = 1'b0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // reset state
        chk_redirect("reset", 1'b0);
        chk("reset_rpc", redirect_pc, 32'h0);
        chk("reset_cnt", {30'd0, mispredict_cnt}, 32'd0);
        chk_pred("reset_pred_100", 32'h100);

        // two correctly predicted taken BEQs train entry 0 to strongly taken
        if_pc = 32'h100;
        resolve("beq1", 3'd0, 32'h100, 32'h180, 1'b1, 1'b1);
        resolve("beq2", 3'd0, 32'h100, 32'h180, 1'b1, 1'b1);
        chk_pred("pred_100", 32'h100);
        chk_pred("pred_140_alias", 32'h140);
        chk("pred_100_taken", {31'd0, if_pred_taken}, 32'd1);

        // counter saturation at 0 then back up through weak states (entry 1)
        if_pc = 32'h104;
        resolve("dec1", 3'd1, 32'h104, 32'h0, 1'b0, 1'b0);
        resolve("dec2", 3'd1, 32'h104, 32'h0, 1'b0, 1'b0);
        resolve("inc1", 3'd6, 32'h104, 32'h0, 1'b1, 1'b1);
        resolve("inc2", 3'd7, 32'h104, 32'h0, 1'b1, 1'b1);
        chk_pred("pred_104", 32'h104);

        // BLT mispredict, fetch stalls the handshake for three cycles
        if_pc = 32'h200;
        resolve("blt", 3'd4, 32'h200, 32'h2000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            // an instruction offered during REDIRECT must be ignored
            ex_valid = 1'b1; ex_br_type = 3'd0; ex_pc = 32'h108;
            ex_pred_taken = 1'b0; br_taken = 1'b1; ex_target = 32'h3000;
            tick();
            ex_valid = 1'b0;
            chk_redirect("hold", 1'b1);
            chk("hold_rpc", redirect_pc, 32'h2000);
            chk("hold_cnt", {30'd0, mispredict_cnt}, 32'd1);
        end
        chk_pred("ignored_no_train", 32'h108);
        redirect_ready = 1'b1;
        tick();
        chk_redirect("hs_done", 1'b0);
        chk("hs_cnt", {30'd0, mispredict_cnt}, 32'd1);

        // BNE not-taken at the top of memory wraps the fall-through PC
        resolve("wrap", 3'd1, 32'hFFFF_FFFC, 32'h4000, 1'b1, 1'b0);
        tick();
        chk_redirect("wrap_done", 1'b0);

        // jump predicted taken: nothing happens, table untouched
        resolve("jump", 3'd3, 32'h308, 32'h5000, 1'b1, 1'b1);
        chk_pred("jump_no_train", 32'h308);

        // never-branch predicted taken: redirect to fall-through, no training
        resolve("never", 3'd2, 32'h30C, 32'h6000, 1'b1, 1'b0);
        tick();
        chk_redirect("never_done", 1'b0);
        chk_pred("never_no_train", 32'h30C);

        // fourth mispredict saturates the 2-bit counter; stay in REDIRECT
        redirect_ready = 1'b0;
        resolve("sat", 3'd5, 32'h400, 32'h500, 1'b0, 1'b1);
        chk("sat_cnt3", {30'd0, mispredict_cnt}, 32'd3);

        // reset during REDIRECT drops the pending redirect
        rst_n = 1'b0;
        tick();
        model_reset();
        chk_redirect("rst_mid", 1'b0);
        chk("rst_mid_rpc", redirect_pc, 32'h0);
        chk("rst_mid_cnt", {30'd0, mispredict_cnt}, 32'd0);
        chk_pred("rst_mid_pred_100", 32'h100);
        chk_pred("rst_mid_pred_104", 32'h104);
        rst_n = 1'b1;
        tick();
        chk_redirect("post_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
